// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a per-grant hold limit; grant appears one cycle after request.
// No backpressure: a holder keeps gnt until it drops req or hits MAX_HOLD, then the next requester takes over at that edge.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     r_state;
  logic [2:0] r_ptr;
  logic [2:0] r_gidx;
  logic [7:0] r_hold_cnt;
  logic [7:0] r_gnt;
  logic       r_gnt_valid;
  logic       r_preempt;

  logic [2:0] w_next_ptr;
  logic [2:0] w_base;
  logic [2:0] w_sel;
  logic       w_hit;
  logic       w_keep;

  assign w_next_ptr = r_gidx + 3'd1;
  // A releasing grant searches from just past itself, so the outgoing holder is checked last.
  assign w_base     = (r_state == GRANT) ? w_next_ptr : r_ptr;
  assign w_keep     = (r_state == GRANT) && req[r_gidx] && (r_hold_cnt != HOLD_LAST);

  always_comb begin
    w_hit = 1'b0;
    w_sel = w_base;
    for (int k = 0; k < 8; k++) begin
      if (!w_hit && req[w_base + 3'(k)]) begin
        w_hit = 1'b1;
        w_sel = w_base + 3'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_gidx      <= '0;
      r_hold_cnt  <= '0;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_preempt   <= 1'b0;
    end else begin
      r_preempt <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_hit) begin
            r_state     <= GRANT;
            r_gidx      <= w_sel;
            r_gnt       <= 8'd1 << w_sel;
            r_gnt_valid <= 1'b1;
            r_hold_cnt  <= '0;
          end
        end
        GRANT: begin
          if (w_keep) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end else begin
            // Holder still requesting here means the hold limit forced the release.
            r_ptr      <= w_next_ptr;
            r_preempt  <= req[r_gidx];
            r_hold_cnt <= '0;
            if (w_hit) begin
              r_gidx      <= w_sel;
              r_gnt       <= 8'd1 << w_sel;
              r_gnt_valid <= 1'b1;
            end else begin
              r_state     <= IDLE;
              r_gnt       <= '0;
              r_gnt_valid <= 1'b0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = r_gnt_valid;
  assign preempt   = r_preempt;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed and randomized checks of rr_arbiter8 at MAX_HOLD of 16, 2 and 1.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req16, req2, req1;
  logic [7:0] gnt16, gnt2, gnt1;
  logic       gv16, gv2, gv1;
  logic       pre16, pre2, pre1;

  int n_cmp = 0;
  int n_err = 0;

  int         run_len [3];
  logic [7:0] last_g  [3];
  int         wait_c  [3][8];

  always #5 clk = ~clk;

  rr_arbiter8 #(.MAX_HOLD(16)) u16 (.clk(clk), .rst_n(rst_n), .req(req16), .gnt(gnt16), .gnt_valid(gv16), .preempt(pre16));
  rr_arbiter8 #(.MAX_HOLD(2))  u2  (.clk(clk), .rst_n(rst_n), .req(req2),  .gnt(gnt2),  .gnt_valid(gv2),  .preempt(pre2));
  rr_arbiter8 #(.MAX_HOLD(1))  u1  (.clk(clk), .rst_n(rst_n), .req(req1),  .gnt(gnt1),  .gnt_valid(gv1),  .preempt(pre1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req16 = '0; req2 = '0; req1 = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Invariants for one instance; rq is the req value sampled at the edge just passed.
  task automatic inv(input int k, input int maxh, input logic [7:0] g, input logic gv,
                     input logic pre, input logic [7:0] rq);
    bit starve;
    starve = 1'b0;
    chk("onehot", 32'($countones(g) <= 1), 1);
    chk("gv_vs_gnt", gv, |g);
    if (g != 0 && g == last_g[k] && !pre) run_len[k]++;
    else run_len[k] = (g != 0) ? 1 : 0;
    last_g[k] = g;
    chk("hold_len", 32'(run_len[k] <= maxh), 1);
    for (int i = 0; i < 8; i++) begin
      if (rq[i] && !g[i]) wait_c[k][i]++;
      else wait_c[k][i] = 0;
      if (wait_c[k][i] > 8 * maxh) starve = 1'b1;
    end
    chk("starve", starve, 0);
  endtask

  initial begin
    logic [7:0] rq16, rq2, rq1;

    // Reset wins even with every request high.
    rst_n = 1'b0;
    req16 = 8'hFF; req2 = 8'hFF; req1 = 8'hFF;
    tick();
    tick();
    chk("rst_gnt16", gnt16, 8'h00);
    chk("rst_gv16", gv16, 0);
    chk("rst_pre16", pre16, 0);
    chk("rst_gnt2", gnt2, 8'h00);
    chk("rst_ptr", u16.r_ptr, 0);
    do_reset();

    // Sole requester, MAX_HOLD=16: forced release in cycle 17 and immediate regrant.
    tick();
    chk("idle_stays", gnt16, 8'h00);
    req16 = 8'h01;
    tick();
    chk("solo_c1_gnt", gnt16, 8'h01);
    chk("solo_c1_gv", gv16, 1);
    chk("solo_c1_pre", pre16, 0);
    for (int c = 2; c <= 16; c++) begin
      tick();
      chk("solo_hold_gnt", gnt16, 8'h01);
      chk("solo_hold_pre", pre16, 0);
    end
    tick();
    chk("solo_c17_pre", pre16, 1);
    chk("solo_c17_gnt", gnt16, 8'h01);
    tick();
    chk("solo_c18_pre", pre16, 0);
    chk("solo_c18_gnt", gnt16, 8'h01);
    req16 = 8'h00;
    tick();

    // All requesting, MAX_HOLD=2: each index twice, preempt on each handover.
    req2 = 8'hFF;
    for (int c = 1; c <= 17; c++) begin
      logic [7:0] e;
      e = 8'h01 << (((c - 1) / 2) % 8);
      tick();
      chk("rr2_gnt", gnt2, e);
      chk("rr2_pre", pre2, (c >= 3 && (c % 2) == 1) ? 1 : 0);
    end
    req2 = 8'h00;

    // MAX_HOLD=1: every grant one cycle; preempt only when the holder still requests.
    req1 = 8'h05;
    tick(); chk("h1_c1_gnt", gnt1, 8'h01); chk("h1_c1_pre", pre1, 0);
    tick(); chk("h1_c2_gnt", gnt1, 8'h04); chk("h1_c2_pre", pre1, 1);
    tick(); chk("h1_c3_gnt", gnt1, 8'h01); chk("h1_c3_pre", pre1, 1);
    tick(); chk("h1_c4_gnt", gnt1, 8'h04); chk("h1_c4_pre", pre1, 1);
    req1 = 8'h00;
    tick(); chk("h1_c5_gnt", gnt1, 8'h00); chk("h1_c5_pre", pre1, 0);

    // Handover with wrap: grant 3, late arrivals ignored, then switch to 0 with ptr 4.
    do_reset();
    req16 = 8'h08;
    tick(); chk("wrap_g3", gnt16, 8'h08);
    req16 = 8'h0D;
    tick(); chk("wrap_ignore_new", gnt16, 8'h08);
    chk("wrap_ptr_hold", u16.r_ptr, 0);
    req16 = 8'h05;
    tick();
    chk("wrap_gnt", gnt16, 8'h01);
    chk("wrap_ptr", u16.r_ptr, 4);
    chk("wrap_pre", pre16, 0);

    // Pointer carried through IDLE steers the next search.
    do_reset();
    req16 = 8'h08;
    tick();
    req16 = 8'h00;
    tick(); chk("ptr_idle_gnt", gnt16, 8'h00);
    req16 = 8'h11;
    tick(); chk("ptr_idle_search", gnt16, 8'h10);

    // Release of requester 7 to idle, pointer wraps to 0.
    do_reset();
    req16 = 8'h80;
    tick(); chk("rel7_gnt", gnt16, 8'h80);
    req16 = 8'h00;
    tick();
    chk("rel7_gnt0", gnt16, 8'h00);
    chk("rel7_gv0", gv16, 0);
    chk("rel7_pre", pre16, 0);
    chk("rel7_ptr", u16.r_ptr, 0);
    tick(); chk("rel7_ptr_idle", u16.r_ptr, 0);
    req16 = 8'h01;
    tick(); chk("rel7_regrant", gnt16, 8'h01);

    // Mid-grant reset drops the round-robin position.
    do_reset();
    req16 = 8'h20;
    tick(); chk("mrst_g5", gnt16, 8'h20);
    rst_n = 1'b0;
    tick();
    chk("mrst_gnt", gnt16, 8'h00);
    chk("mrst_gv", gv16, 0);
    chk("mrst_ptr", u16.r_ptr, 0);
    rst_n = 1'b1;
    req16 = 8'h21;
    tick(); chk("mrst_after", gnt16, 8'h01);

    // Request pulse between edges is not seen.
    do_reset();
    tick();
    #3 req16 = 8'hFF;
    #4 req16 = 8'h00;
    tick(); chk("glitch", gnt16, 8'h00);

    // Random sticky requests with invariant checks on all three instances.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      run_len[k] = 0;
      last_g[k]  = '0;
      for (int i = 0; i < 8; i++) wait_c[k][i] = 0;
    end
    for (int c = 0; c < 10000; c++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(15) == 0) req16[b] = ~req16[b];
        if ($urandom_range(15) == 0) req2[b]  = ~req2[b];
        if ($urandom_range(15) == 0) req1[b]  = ~req1[b];
      end
      rq16 = req16; rq2 = req2; rq1 = req1;
      tick();
      inv(0, 16, gnt16, gv16, pre16, rq16);
      inv(1, 2,  gnt2,  gv2,  pre2,  rq2);
      inv(2, 1,  gnt1,  gv1,  pre1,  rq1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 Parameter MAX_HOLD, default 16, meaning the maximum number of consecutive cycles one grant may be held; legal range 1..256.
REQ-002 clk  input  1  meaning the single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  meaning reset, synchronous and active-low.
REQ-004 req  input  8  meaning request lines; bit i high means requester i wants service.
REQ-005 gnt  output  8  meaning the registered grant, one-hot or all-zero; it drives the downstream 8-to-3 encoder input.
REQ-006 gnt_valid  output  1  meaning registered; high exactly when gnt is non-zero.
REQ-007 preempt  output  1  meaning a registered one-cycle pulse indicating a grant was forcibly ended by the hold limit.

Function
REQ-008 Internal state SHALL be: a two-state FSM (IDLE, GRANT), a 3-bit priority pointer ptr, and an 8-bit hold counter hold_cnt.
REQ-009 gnt SHALL never have more than one bit set, in any cycle including reset.
REQ-010 Search rule: the selected index SHALL be the first i with req[i]=1, scanning ptr, ptr+1, ... ptr+7 modulo 8 (wrap 7 to 0).
REQ-011 IDLE, req=0: the block SHALL remain in IDLE with gnt=0.
REQ-012 IDLE, req!=0 sampled at edge E: the block SHALL load gnt with the selected one-hot at E, set hold_cnt=0, and enter GRANT; grant latency is one cycle.
REQ-013 GRANT, req[g]=1 and hold_cnt<MAX_HOLD-1 at an edge: gnt SHALL hold and hold_cnt SHALL increment.
REQ-014 GRANT, req[g]=0 at an edge: this is a normal release, and preempt SHALL stay 0.
REQ-015 GRANT, req[g]=1 and hold_cnt==MAX_HOLD-1 at an edge: this is a forced release, and preempt SHALL be 1 for exactly the following cycle.
REQ-016 Grant length: a single grant SHALL therefore last at most MAX_HOLD cycles.
REQ-017 On any release at edge E, ptr SHALL become (g+1) mod 8.
REQ-018 After release at E, the search SHALL run on req at E using the new ptr.
  - Hit: gnt switches directly to the new one-hot at E (no gap cycle), hold_cnt=0, and the FSM stays in GRANT.
  - Miss: gnt=0 and the FSM goes to IDLE.
REQ-019 A preempted requester still asserting req SHALL be regranted immediately only if no other request is pending, since it is searched last.
REQ-020 ptr SHALL change only on release; it is unchanged while in IDLE or while holding.
REQ-021 A new request arriving while another is granted SHALL have no effect on gnt until release.
REQ-022 MAX_HOLD=1: every grant SHALL last exactly one cycle, and preempt SHALL pulse after each grant whose req is still high.
REQ-023 req changes between edges SHALL have no effect; only edge-sampled values matter.

Reset
REQ-024 When rst_n=0 at an edge, the block SHALL set gnt=0, gnt_valid=0, preempt=0, ptr=0, hold_cnt=0, and FSM=IDLE.
REQ-025 Reset SHALL take priority over all other activity, including mid-grant.
REQ-026 The first edge with rst_n=1 SHALL behave as IDLE with ptr=0, so a mid-grant reset loses the round-robin position.
REQ-027 Outputs SHALL be driven from registers only, with no combinational path from req to any output.

Verification
REQ-028 Reset then req=8'b00000001 held: gnt=8'b00000001 one cycle later and gnt_valid=1; with MAX_HOLD=16, preempt=1 in cycle 17, then gnt=8'b00000001 again (sole requester).
REQ-029 req=8'b11111111 held, MAX_HOLD=2: gnt sequence 01,01,02,02,04,04,...,80,80,01 (hex); preempt pulses after every second grant cycle.
REQ-030 Grant bit 3 with ptr=4; req=8'b00001000 drops while req=8'b00000101 is pending: gnt switches at the same edge to 8'b00000001 (wrap past 7), ptr=4, preempt=0.
REQ-031 req=8'b10000000 granted, then req drops to 0: gnt=0, gnt_valid=0 next cycle, ptr=0; a later req=8'b00000001 is granted after one cycle.
REQ-032 rst_n=0 mid-grant with gnt=8'b00100000: gnt=0 and ptr=0 after the edge; with req=8'b00100001 and rst_n=1 next edge, gnt=8'b00000001.
REQ-033 Random req for 10k cycles: a checker confirms gnt is one-hot or zero every cycle, gnt_valid==|gnt, no grant exceeds MAX_HOLD cycles, and every continuously asserted request is granted within 8*MAX_HOLD cycles.
